mm_mult_149x149_seq: RTL and testbench

Sequential full-width 149×149-bit multiplier for the modular-multiplication datapath. It splits operand `b` into five 32-bit chunks and issues them back-to-back to one `mult_149x32` instance. As each 181-bit partial product returns, it is shifted into place and accumulated into a 298-bit product. Upstream it takes operand pairs over a valid/ready handshake; downstream it presents the full product, held, to the reduction stage.

---
 rtl/mm_pkg.sv | 12 +
 rtl/mult_149x32.sv | 28 ++
 rtl/mm_mult_149x149_seq.sv | 120 ++++++++++++
 tb/tb_mm_mult_149x149_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared constants and FSM state type for the modular-multiplication datapath.
package mm_pkg;
  localparam int MM_A_W     = 149;
  localparam int MM_B_W     = 149;
  localparam int MM_CHUNK_W = 32;
  localparam int MM_N_CHUNK = 5;
  localparam int MM_P_W     = 298;
  localparam int MM_PP_W    = MM_A_W + MM_CHUNK_W;
  localparam int MM_IDX_W   = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} mm_state_e;
endpackage

// File: rtl/mult_149x32.sv
// Pipelined 149x32 unsigned multiplier, fixed 3-cycle latency, no reset.
module mult_149x32
  import mm_pkg::*;
(
  input  logic                  clk,
  input  logic [MM_A_W-1:0]     a,
  input  logic [MM_CHUNK_W-1:0] b,
  output logic [MM_PP_W-1:0]    p
);
  logic [MM_A_W-1:0]     a_p0;
  logic [MM_CHUNK_W-1:0] b_p0;
  logic [MM_PP_W-1:0]    prod_p1;
  logic [MM_PP_W-1:0]    prod_p2;

  // stage 0: operand capture
  always_ff @(posedge clk) begin
    a_p0 <= a;
    b_p0 <= b;
  end

  // stage 1: multiply, stage 2: output register
  always_ff @(posedge clk) begin
    prod_p1 <= MM_PP_W'(a_p0) * MM_PP_W'(b_p0);
    prod_p2 <= prod_p1;
  end

  assign p = prod_p2;
endmodule

// File: rtl/mm_mult_149x149_seq.sv
// Sequential 149x149 multiplier: b is fed to one mult_149x32 in five 32-bit
// chunks and the shifted partial products are accumulated into a 298-bit result.
module mm_mult_149x149_seq
  import mm_pkg::*;
#(
  parameter int MULT_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MM_A_W-1:0] a,
  input  logic [MM_B_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MM_P_W-1:0] p
);
  localparam int BEXT_W = MM_CHUNK_W * MM_N_CHUNK;

  mm_state_e state, state_nxt;

  logic [MM_A_W-1:0]     a_q;
  logic [MM_B_W-1:0]     b_q;
  logic [BEXT_W-1:0]     b_ext;
  logic [MM_CHUNK_W-1:0] chunk;
  logic [MM_IDX_W-1:0]   cnt;
  logic [MM_P_W-1:0]     acc;
  logic [MM_PP_W-1:0]    pp;

  logic                tag_vld_p [MULT_LAT];
  logic [MM_IDX_W-1:0] tag_idx_p [MULT_LAT];

  logic accept, issue, last_chunk, pp_vld, last_pp;
  logic [MM_IDX_W-1:0] pp_idx;

  function automatic logic [MM_P_W-1:0] place_partial(input logic [MM_PP_W-1:0] part,
                                                      input logic [MM_IDX_W-1:0] idx);
    return MM_P_W'(part) << {idx, 5'b0};
  endfunction

  assign accept     = in_valid && in_ready;
  assign issue      = (state == ISSUE);
  assign last_chunk = (cnt == MM_IDX_W'(MM_N_CHUNK - 1));
  assign pp_vld     = tag_vld_p[MULT_LAT-1];
  assign pp_idx     = tag_idx_p[MULT_LAT-1];
  assign last_pp    = pp_vld && (pp_idx == MM_IDX_W'(MM_N_CHUNK - 1));

  // top chunk is zero-extended so every chunk select stays in range
  assign b_ext = BEXT_W'(b_q);
  assign chunk = b_ext[{cnt, 5'b0} +: MM_CHUNK_W];

  mult_149x32 u_mult (
    .clk (clk),
    .a   (a_q),
    .b   (chunk),
    .p   (pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: if (last_chunk) state_nxt = DRAIN;
      DRAIN: if (last_pp) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (accept)              cnt <= '0;
    else if (issue && !last_chunk) cnt <= cnt + 1'b1;
  end

  // tag pipeline mirrors the multiplier latency so each partial arrives with its index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_vld_p[i] <= 1'b0;
        tag_idx_p[i] <= '0;
      end
    end else begin
      tag_vld_p[0] <= issue;
      tag_idx_p[0] <= cnt;
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_idx_p[i] <= tag_idx_p[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (accept) acc <= '0;
    else if (pp_vld) acc <= acc + place_partial(pp, pp_idx);
  end

  assign p = acc;
endmodule

// File: tb/tb_mm_mult_149x149_seq.sv
// Scoreboard bench for mm_mult_149x149_seq: directed operand pairs with hand-derived products.
module tb_mm_mult_149x149_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [148:0] a = '0;
  logic [148:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [297:0] p;

  int n_pass = 0;
  int n_total = 0;
  logic [297:0] sb[$];

  mm_mult_149x149_seq #(.MULT_LAT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b want %0b", nm, act, exp);
  endtask

  task automatic chk_p(input string nm, input logic [297:0] act, input logic [297:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // monitor: every output handshake is compared against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk_bit("unexpected_output", 1'b1, 1'b0);
      end else begin
        chk_p("product", p, sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [148:0] aa, input logic [148:0] bb,
                       input logic [297:0] exp, input bit push);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = aa; b = bb;
    for (int g = 0; g < 50 && !ok; g++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk_bit("accept_timeout", 1'b0, 1'b1);
    if (push) sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int g = 0; g < 60 && !seen; g++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) chk_bit("out_valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic run(input logic [148:0] aa, input logic [148:0] bb, input logic [297:0] exp);
    issue(aa, bb, exp, 1'b1);
    wait_valid();
    @(posedge clk); #1;
  endtask

  // checks cycle-exact timing: out_valid only in cycle 9, in_ready low cycles 1..9, high in 10
  task automatic run_timed(input logic [148:0] aa, input logic [148:0] bb, input logic [297:0] exp);
    issue(aa, bb, exp, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk_bit($sformatf("in_ready_c%0d", c), in_ready, 1'b0);
      chk_bit($sformatf("out_valid_c%0d", c), out_valid, (c == 9));
    end
    @(negedge clk);
    chk_bit("in_ready_after_hs", in_ready, 1'b1);
  endtask

  logic [297:0] e_full;
  logic [297:0] e_bp;

  initial begin
    e_full = {298{1'b1}} - (298'd1 << 150) + 298'd2;
    e_bp   = 298'h3_0000_0000;

    #1 rst_n = 1'b0;
    #1;
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_p("rst_p", p, 298'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_timed(149'd1, 149'd1, 298'd1);
    run({149{1'b1}}, {149{1'b1}}, e_full);
    run(149'd3, 149'd1 << 128, 298'd3 << 128);
    run(149'hDEADBEEF, 149'h1_0000_0001, 298'hDEADBEEF_DEADBEEF);

    // backpressure: result held while new operands wait
    out_ready = 1'b0;
    issue(149'h1234_5678, 149'h1_0000, 298'h1234_5678_0000, 1'b1);
    wait_valid();
    @(posedge clk); #1;
    in_valid = 1'b1; a = 149'h3; b = 149'h1_0000_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_bit($sformatf("bp_out_valid_%0d", c), out_valid, 1'b1);
      chk_p($sformatf("bp_p_stable_%0d", c), p, 298'h1234_5678_0000);
      chk_bit($sformatf("bp_in_ready_%0d", c), in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_bit("bp_in_ready_after_hs", in_ready, 1'b1);
    sb.push_back(e_bp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid();
    @(posedge clk); #1;

    // reset in cycle 4 of an operation that must never produce output
    issue(149'd1 << 148, 149'd1 << 148, 298'd0, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_bit("midrst_out_valid", out_valid, 1'b0);
    chk_bit("midrst_in_ready", in_ready, 1'b1);
    chk_p("midrst_p", p, 298'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk_bit("aborted_no_output", seen, 1'b0);
    end
    run_timed(149'd5, 149'd7, 298'd35);

    repeat (3) @(negedge clk);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drained: got %0d pending want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
